// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop synchronizer, debounce, edge pulses
// and optional auto-repeat while a key is held.
module key_conditioner #(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int unsigned DEB_CYC  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int unsigned DLY_CYC  = CLK_FREQ_HZ / 1000 * REPEAT_DELAY_MS;
    localparam int unsigned RATE_CYC = CLK_FREQ_HZ / 1000 * REPEAT_RATE_MS;
    localparam int unsigned RMAX     = (DLY_CYC > RATE_CYC) ? DLY_CYC : RATE_CYC;
    localparam int unsigned DCNT_W   = $clog2(DEB_CYC + 1);
    localparam int unsigned RCNT_W   = $clog2(RMAX + 1);

    localparam logic [DCNT_W-1:0] DEB_LAST  = DCNT_W'(DEB_CYC - 1);
    localparam logic [RCNT_W-1:0] DLY_LAST  = RCNT_W'(DLY_CYC - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST = RCNT_W'(RATE_CYC - 1);

    // Reject parameter sets whose derived cycle counts collapse to zero
    if (DEB_CYC < 1 || DLY_CYC < 1 || RATE_CYC < 1) begin : g_param_err
        $error("key_conditioner: derived cycle counts must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    // Two-flop synchronizer; resets to the released (high) level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        logic [DCNT_W-1:0] dcnt_q;
        logic [RCNT_W-1:0] rcnt_q;
        state_e            state_q;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              s;
        logic              flip;
        logic              rise;
        logic              fall;

        assign s    = ~sync2_q[g];
        assign flip = (s != level_q) && (dcnt_q == DEB_LAST);
        assign rise = flip & s;
        assign fall = flip & ~s;

        // Debounce counter, debounced level and press/repeat/release FSM
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dcnt_q    <= '0;
                rcnt_q    <= '0;
                state_q   <= ST_IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;

                if (s == level_q || flip) begin
                    dcnt_q <= '0;
                end else begin
                    dcnt_q <= dcnt_q + DCNT_W'(1);
                end
                if (flip) begin
                    level_q <= s;
                end

                if (fall) begin
                    state_q   <= ST_IDLE;
                    release_q <= 1'b1;
                    rcnt_q    <= '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            rcnt_q <= '0;
                            if (rise) begin
                                state_q <= ST_HELD;
                                press_q <= 1'b1;
                            end
                        end
                        ST_HELD, ST_REPEAT: begin
                            if (!repeat_en[g]) begin
                                state_q <= ST_HELD;
                                rcnt_q  <= '0;
                            end else if (rcnt_q == ((state_q == ST_HELD) ? DLY_LAST : RATE_LAST)) begin
                                state_q <= ST_REPEAT;
                                press_q <= 1'b1;
                                rcnt_q  <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + RCNT_W'(1);
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            rcnt_q  <= '0;
                        end
                    endcase
                end
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw DE1-SoC push-buttons into clean, single-cycle events for the game-play logic.
- KEY pulses from this block feed screen_fsm `enter` and the cursor/move logic.
- Per key: 2-flop synchronizer, debounce counter, edge detector, and optional auto-repeat for held keys (cursor sweeping).
- All keys are independent identical lanes; no cross-key interaction.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clk frequency in Hz.
- NUM_KEYS, 4, number of independent key lanes.
- DEBOUNCE_MS, 10, time the synchronized input must be stable before the debounced level changes.
- REPEAT_DELAY_MS, 500, hold time from the initial press pulse to the first repeat pulse.
- REPEAT_RATE_MS, 100, interval between successive repeat pulses.
- Derived cycle counts: DEB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS; DLY_CYC and RATE_CYC are computed the same way.
- Elaboration error if any derived count is < 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- key_n  input  NUM_KEYS  raw asynchronous buttons, active-low (0 = pressed).
- repeat_en  input  NUM_KEYS  per-key auto-repeat enable, synchronous to clk.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- key_press  output  NUM_KEYS  1-cycle pulse on debounced press and on each auto-repeat.
- key_release  output  NUM_KEYS  1-cycle pulse on debounced release.

Behaviour:
- Clock and reset: clk is the clock; reset_n is the reset, asynchronous, active-low.
- Reset values:
  - Synchronizer flops = 1 (released).
  - key_level = 0, key_press = 0, key_release = 0.
  - All counters = 0; all lanes in IDLE.
- Synchronizer:
  - key_n passes through 2 flops, then inverts to s (1 = pressed).
  - No logic is permitted before the second flop.
- Debounce, per lane:
  - Counter dcnt is cleared whenever s == key_level.
  - dcnt increments each cycle that s != key_level.
  - When s != key_level and dcnt == DEB_CYC-1, the next edge toggles key_level and clears dcnt.
  - Result: the level flips after exactly DEB_CYC consecutive differing samples.
  - Any single matching sample restarts the count (glitch rejection).
- Latency: a key_n edge held stable changes key_level 2 + DEB_CYC cycles later.
- Edge pulses:
  - key_press is high in exactly the first cycle key_level reads 1.
  - key_release is high in exactly the first cycle key_level reads 0.
  - All outputs are registered.
- Per-lane FSM states:
  - IDLE: key_level = 0. On debounced press → HELD, pulse key_press, clear rcnt.
  - HELD: rcnt increments each cycle while repeat_en = 1.
    - When rcnt == DLY_CYC-1 → REPEAT, pulse key_press, clear rcnt.
    - Pulse spacing: the first repeat pulse comes exactly DLY_CYC cycles after the initial press pulse.
  - REPEAT: rcnt increments.
    - When rcnt == RATE_CYC-1, pulse key_press and clear rcnt.
    - Pulse spacing: successive repeat pulses are exactly RATE_CYC cycles apart.
  - Any state, debounced release → IDLE, pulse key_release, clear rcnt, no key_press that cycle.
  - HELD/REPEAT with repeat_en = 0: rcnt held at 0; REPEAT returns to HELD.
    - Re-assertion restarts the full DLY_CYC delay.
    - No pulses while disabled.
  - Illegal state encoding → IDLE.
- Boundary conditions:
  - Simultaneous press on several keys: lanes act independently; multiple key_press bits may be high in the same cycle.
  - Bounce during the release debounce window: key_level stays 1 and repeats continue until release is confirmed.
  - Counter widths: $clog2(max count + 1); no wrap is reachable.
  - Reset mid-operation: immediate return to reset values; no pulse is emitted on reset deassertion, even if a key is physically held.
  - Held keys are detected only through the normal debounce path after reset.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ_HZ = 1000, DEBOUNCE_MS = 4, REPEAT_DELAY_MS = 20, REPEAT_RATE_MS = 5, NUM_KEYS = 4, giving DEB_CYC = 4, DLY_CYC = 20, RATE_CYC = 5.
1. Clean press, repeat_en = 0: key_n[0] 1→0 at cycle 0, held 50 cycles → key_level[0] rises at cycle 6; one key_press[0] pulse at cycle 6; no further pulses.
2. Glitch rejection: key_n[1] low for 3 cycles, high for 1, repeated 10 times → key_level[1] stays 0; key_press never asserts.
3. Auto-repeat, repeat_en[2] = 1, key held 60 cycles → key_press[2] pulses at cycles 6, 26, 31, 36, 41, …; key_release[2] pulses exactly 6 cycles after the key_n[2] rising edge, with no key_press that cycle.
4. repeat_en[2] dropped at cycle 28 and raised at cycle 40 during a hold → no pulses from 28 to 59; next pulse at cycle 60.
5. Simultaneous press: keys 0 and 3 pressed in the same cycle → key_press = 4'b1001 in a single cycle.
6. Reset mid-hold: reset_n asserted at cycle 30 of a repeat sequence, released at 35 with the key still low → all outputs 0 during reset; key_level returns to 1 and key_press pulses 6 cycles after release, with repeats restarting from the full delay.
